mbgd_grad_update: RTL and testbench

//  Backward path of the MBGD datapath. Consumes the summed dot-product output of the forward adder, forms the

---
 rtl/mbgd_pkg.sv | 43 ++++
 rtl/mbgd_lane_mac.sv | 37 +++
 rtl/mbgd_grad_update.sv | 197 +++++++++++++++++++
 tb/tb_mbgd_grad_update.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mbgd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mbgd_pkg
//  Purpose  : Shared types and helpers for the MBGD backward (gradient
//             update) path: FSM state encoding, derived-width functions and
//             the packed-lane slice helper.
//  Contents : state_t          - FSM state encoding
//             calc_sw/calc_gw  - sum width / gradient accumulator width
//             SW, GW           - derived widths for the default configuration
//             lane_lsb         - LSB position of lane i in a packed vector
//  Revision : 1.0 - initial release
// ============================================================================
package mbgd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Forward sum width: DW1 x DW2 product summed over 2^N_BIT lanes.
  function automatic int calc_sw(input int dw1, input int dw2, input int n_bit);
    return dw1 + dw2 + n_bit;
  endfunction

  // Gradient accumulator: signed residual (SW+1) times unsigned feature,
  // summed over 2^BATCH_BIT samples.
  function automatic int calc_gw(input int dw1, input int dw2, input int n_bit,
                                 input int batch_bit);
    return calc_sw(dw1, dw2, n_bit) + 1 + dw1 + batch_bit;
  endfunction

  localparam int SW = calc_sw(8, 8, 3);
  localparam int GW = calc_gw(8, 8, 3, 2);

  // Lane i of a packed vector occupies [width*(i+1)-1 : width*i].
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mbgd_lane_mac.sv
`default_nettype none
// ============================================================================
//  Module   : mbgd_lane_mac
//  Purpose  : Shared multiply-accumulate for the gradient path:
//             acc_next = acc + err * {1'b0, x}
//  Ports    : err      in  SW+1  signed residual
//             x        in  DW1   unsigned feature of the selected lane
//             acc      in  GW    signed gradient of the selected lane
//             acc_next out GW    updated gradient
//  Revision : 1.0 - initial release
// ============================================================================
module mbgd_lane_mac
  import mbgd_pkg::*;
#(
  parameter int SW  = 19,
  parameter int DW1 = 8,
  parameter int GW  = 30
) (
  input  logic signed [SW:0]    err,
  input  logic        [DW1-1:0] x,
  input  logic signed [GW-1:0]  acc,
  output logic signed [GW-1:0]  acc_next
);

  logic signed [GW-1:0] w_err_ext;
  logic signed [GW-1:0] w_x_ext;
  logic signed [GW-1:0] w_prod;

  // Both operands are widened to the accumulator width first; the true
  // product always fits in GW bits, so the truncated multiply is exact.
  assign w_err_ext = {{(GW-SW-1){err[SW]}}, err};
  assign w_x_ext   = {{(GW-DW1){1'b0}}, x};
  assign w_prod    = w_err_ext * w_x_ext;
  assign acc_next  = acc + w_prod;

endmodule
`default_nettype wire

// File: rtl/mbgd_grad_update.sv
`default_nettype none
// ============================================================================
//  Module   : mbgd_grad_update
//  Purpose  : Backward path of the MBGD datapath. Forms the residual
//             sum_in - label per sample, accumulates err*x_i into per-lane
//             gradients over a mini-batch (one lane per cycle through a
//             shared MAC) and, at batch end, updates the packed weights with
//             w - grad >>> (LR_SHIFT+BATCH_BIT), saturated to [0, 2^DW2-1].
//  Ports    : clk, resetn (async, active-low)
//             w_load/w_init        - weight initialisation (IDLE only)
//             in_valid/in_ready    - sample handshake
//             sum_in, label        - forward sum and target, unsigned SW bits
//             features             - packed DW1 x N sample features
//             weights              - packed DW2 x N current weights
//             upd_valid            - one-cycle pulse after a weight update
//             busy                 - FSM not idle
//  Revision : 1.0 - initial release
// ============================================================================
module mbgd_grad_update
  import mbgd_pkg::*;
#(
  parameter  int N         = 8,
  parameter  int N_BIT     = 3,
  parameter  int DW1       = 8,
  parameter  int DW2       = 8,
  parameter  int BATCH     = 4,
  parameter  int BATCH_BIT = 2,
  parameter  int LR_SHIFT  = 4,
  localparam int SW        = calc_sw(DW1, DW2, N_BIT),
  localparam int GW        = calc_gw(DW1, DW2, N_BIT, BATCH_BIT)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             w_load,
  input  logic [DW2*N-1:0] w_init,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SW-1:0]    sum_in,
  input  logic [SW-1:0]    label,
  input  logic [DW1*N-1:0] features,
  output logic [DW2*N-1:0] weights,
  output logic             upd_valid,
  output logic             busy
);

  localparam logic [N_BIT-1:0]     c_last_lane  = N_BIT'(N - 1);
  localparam logic [BATCH_BIT-1:0] c_last_batch = BATCH_BIT'(BATCH - 1);
  localparam int                   c_shift      = LR_SHIFT + BATCH_BIT;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [N_BIT-1:0]        r_lane;
  logic [BATCH_BIT-1:0]    r_batch;
  logic signed [SW:0]      r_err;
  logic [DW1-1:0]          r_feat    [N];
  logic [DW2-1:0]          r_weights [N];
  logic signed [GW-1:0]    r_grad    [N];

  logic                    w_last_lane;
  logic signed [GW-1:0]    w_grad_next;
  logic signed [GW-1:0]    w_grad_shr;
  logic signed [GW:0]      w_t;
  logic [DW2-1:0]          w_w_sat;

  assign w_last_lane = (r_lane == c_last_lane);

  // --------------------------------------------------------------------------
  // Shared MAC, fed by the lane currently selected by r_lane.
  // --------------------------------------------------------------------------
  mbgd_lane_mac #(
    .SW  (SW),
    .DW1 (DW1),
    .GW  (GW)
  ) u_mac (
    .err      (r_err),
    .x        (r_feat[r_lane]),
    .acc      (r_grad[r_lane]),
    .acc_next (w_grad_next)
  );

  // --------------------------------------------------------------------------
  // Weight update for the selected lane: the batch average and learning rate
  // collapse into one arithmetic shift (rounds toward minus infinity). The
  // difference is one bit wider than the gradient so it can never wrap.
  // --------------------------------------------------------------------------
  always_comb begin
    w_grad_shr = r_grad[r_lane] >>> c_shift;
    w_t        = $signed({{(GW+1-DW2){1'b0}}, r_weights[r_lane]})
               - $signed({w_grad_shr[GW-1], w_grad_shr});
    if (w_t[GW]) begin
      w_w_sat = '0;
    end else if (|w_t[GW-1:DW2]) begin
      w_w_sat = '1;
    end else begin
      w_w_sat = w_t[DW2-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    busy         = 1'b1;
    upd_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (!w_load && in_valid) begin
          w_next_state = ACCUM;
        end
      end
      ACCUM: begin
        if (w_last_lane) begin
          w_next_state = (r_batch == c_last_batch) ? UPDATE : IDLE;
        end
      end
      UPDATE: begin
        if (w_last_lane) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        upd_valid    = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers. r_lane wraps to 0 naturally after the last lane, so
  // ACCUM hands over to UPDATE already pointing at lane 0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lane  <= '0;
      r_batch <= '0;
      r_err   <= '0;
      for (int i = 0; i < N; i++) begin
        r_feat[i]    <= '0;
        r_weights[i] <= '0;
        r_grad[i]    <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_batch <= '0;
            for (int i = 0; i < N; i++) begin
              r_weights[i] <= w_init[lane_lsb(i, DW2) +: DW2];
              r_grad[i]    <= '0;
            end
          end else if (in_valid) begin
            r_err  <= $signed({1'b0, sum_in}) - $signed({1'b0, label});
            r_lane <= '0;
            for (int i = 0; i < N; i++) begin
              r_feat[i] <= features[lane_lsb(i, DW1) +: DW1];
            end
          end
        end
        ACCUM: begin
          r_grad[r_lane] <= w_grad_next;
          r_lane         <= r_lane + 1'b1;
          if (w_last_lane) begin
            r_batch <= r_batch + 1'b1;
          end
        end
        UPDATE: begin
          r_weights[r_lane] <= w_w_sat;
          r_grad[r_lane]    <= '0;
          r_lane            <= r_lane + 1'b1;
          if (w_last_lane) begin
            r_batch <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_pack_weights
    assign weights[lane_lsb(gi, DW2) +: DW2] = r_weights[gi];
  end

endmodule
`default_nettype wire

// File: tb/tb_mbgd_grad_update.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mbgd_grad_update
//  Purpose  : Self-checking bench for mbgd_grad_update: table of full
//             mini-batches with hand-computed final weights, plus directed
//             sequences for handshake timing, w_load priority and mid-batch
//             reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mbgd_grad_update;

  localparam int N   = 8;
  localparam int DW1 = 8;
  localparam int DW2 = 8;
  localparam int SW  = 19;

  logic             clk      = 1'b0;
  logic             resetn   = 1'b0;
  logic             w_load   = 1'b0;
  logic [DW2*N-1:0] w_init   = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [SW-1:0]    sum_in   = '0;
  logic [SW-1:0]    label    = '0;
  logic [DW1*N-1:0] features = '0;
  logic [DW2*N-1:0] weights;
  logic             upd_valid;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mbgd_grad_update dut (
    .clk       (clk),
    .resetn    (resetn),
    .w_load    (w_load),
    .w_init    (w_init),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .label     (label),
    .features  (features),
    .weights   (weights),
    .upd_valid (upd_valid),
    .busy      (busy)
  );

  typedef struct {
    logic [63:0]   winit;
    logic [63:0]   feat;
    logic [SW-1:0] sum;
    logic [SW-1:0] lbl;
    logic [63:0]   expw;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Returns at a falling edge with in_ready high (or after a bounded wait).
  task automatic wait_ready(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check({name, " ready_timeout"}, 64'(in_ready), 64'd1);
  endtask

  task automatic load_weights(input logic [63:0] w, input string name);
    wait_ready(name);
    w_load = 1'b1;
    w_init = w;
    @(posedge clk);
    #1 w_load = 1'b0;
  endtask

  task automatic send_sample(input logic [SW-1:0] s, input logic [SW-1:0] l,
                             input logic [63:0] f, input string name);
    wait_ready(name);
    in_valid = 1'b1;
    sum_in   = s;
    label    = l;
    features = f;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts falling edges after an accept edge until upd_valid is seen.
  task automatic wait_upd(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!upd_valid && k < 60);
  endtask

  // Full batch: load, four identical samples, then check update timing/result.
  // The update pulse sits N ACCUM + N UPDATE cycles after the 4th accept edge,
  // i.e. on the (2N+1)th falling edge.
  task automatic run_batch(input vec_t v, input string name);
    int k;
    load_weights(v.winit, name);
    for (int s = 0; s < 4; s++) send_sample(v.sum, v.lbl, v.feat, name);
    wait_upd(k);
    check({name, " upd_latency"}, 64'(k), 64'(2 * N + 1));
    check({name, " weights"}, weights, v.expw);
    check({name, " ready_in_done"}, 64'(in_ready), 64'd0);
    @(negedge clk);
    check({name, " upd_single_pulse"}, 64'(upd_valid), 64'd0);
  endtask

  initial begin
    int k;
    int nacc;
    int upd_at;
    int acc_at [4];

    // basic batch: err=64, grad 256 -> 4
    vecs[0] = '{{8{8'd16}}, {8{8'd1}}, 19'd100, 19'd36, {8{8'd12}}};
    // negative residual, upper clamp
    vecs[1] = '{{8{8'd250}}, {8{8'd255}}, 19'd0, 19'd500, {8{8'd255}}};
    // lower clamp on lanes 0..3, zero feature lanes 4..7 keep 2
    vecs[2] = '{{8{8'd2}}, 64'h00000000_FFFFFFFF, 19'd500, 19'd0, 64'h02020202_00000000};
    // per-lane features 10*i, err=10: w = 100 - floor(40*x/64)
    vecs[3] = '{{8{8'd100}}, 64'h463C3228_1E140A00, 19'd50, 19'd40, 64'h393F454B_52585E64};
    // err=-1: grad -4 >>> 6 = -1, weight rises by one
    vecs[4] = '{{8{8'd10}}, {8{8'd1}}, 19'd0, 19'd1, {8{8'd11}}};
    // err=+1: grad 4 >>> 6 = 0, weight unchanged
    vecs[5] = '{{8{8'd10}}, {8{8'd1}}, 19'd1, 19'd0, {8{8'd10}}};

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset busy", 64'(busy), 64'd0);
    check("reset upd_valid", 64'(upd_valid), 64'd0);
    check("reset weights", weights, 64'd0);
    resetn = 1'b1;

    // ---------------- table-driven batches ----------------
    for (int i = 0; i < 6; i++) run_batch(vecs[i], $sformatf("vec%0d", i));

    // ---------------- handshake with in_valid held ----------------
    load_weights({8{8'd16}}, "hs");
    wait_ready("hs");
    in_valid = 1'b1;
    sum_in   = 19'd100;
    label    = 19'd36;
    features = {8{8'd1}};
    nacc     = 0;
    upd_at   = -1;
    for (int c = 0; c < 80; c++) begin
      if (upd_valid) begin
        upd_at = c;
        break;
      end
      if (in_ready) begin
        if (nacc < 4) acc_at[nacc] = c;
        nacc++;
      end
      @(negedge clk);
    end
    check("hs ready_in_done", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    check("hs accept_count", 64'(nacc), 64'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("hs accept%0d_cycle", i), 64'(acc_at[i]), 64'(i * (N + 1)));
    check("hs upd_cycle", 64'(upd_at), 64'(3 * (N + 1) + 2 * N + 1));
    check("hs weights", weights, {8{8'd12}});

    // ---------------- w_load priority and ACCUM-time w_load ----------------
    send_sample(19'd500, 19'd0, {8{8'd255}}, "wl");
    send_sample(19'd500, 19'd0, {8{8'd255}}, "wl");
    wait_ready("wl");
    w_load   = 1'b1;
    w_init   = {8{8'd16}};
    in_valid = 1'b1;
    sum_in   = 19'd100;
    label    = 19'd36;
    features = {8{8'd1}};
    @(posedge clk);
    #1;
    w_load   = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("wl sample_dropped busy", 64'(busy), 64'd0);
    check("wl sample_dropped ready", 64'(in_ready), 64'd1);
    check("wl weights_loaded", weights, {8{8'd16}});
    send_sample(19'd100, 19'd36, {8{8'd1}}, "wl");
    @(negedge clk);
    w_load = 1'b1;
    w_init = {8{8'h55}};
    @(posedge clk);
    #1 w_load = 1'b0;
    @(negedge clk);
    check("wl ignored_in_accum", weights, {8{8'd16}});
    for (int s = 0; s < 3; s++) send_sample(19'd100, 19'd36, {8{8'd1}}, "wl");
    wait_upd(k);
    check("wl upd_latency", 64'(k), 64'(2 * N + 1));
    check("wl weights", weights, {8{8'd12}});

    // ---------------- reset at lane 3 of the 2nd ACCUM ----------------
    load_weights({8{8'd16}}, "rst");
    send_sample(19'd100, 19'd36, {8{8'd1}}, "rst");
    send_sample(19'd100, 19'd36, {8{8'd1}}, "rst");
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midrst in_ready", 64'(in_ready), 64'd1);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst upd_valid", 64'(upd_valid), 64'd0);
    check("midrst weights", weights, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_batch(vecs[0], "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
